// File: rtl/fp_spec_pkg.sv
// Shared constants, flag vector type and narrow-pack helper for the
// special-case select/pack pipeline.
package fp_spec_pkg;

   localparam int EW_DEF  = 11;
   localparam int FW_DEF  = 52;
   localparam int SEW_DEF = 8;
   localparam int SFW_DEF = 23;
   localparam int NW_DEF  = 1 + SEW_DEF + SFW_DEF;

   localparam int FLG_INV = 0;
   localparam int FLG_DBZ = 1;
   localparam int FLG_OVF = 2;
   localparam int FLG_UNF = 3;
   localparam int FLG_INX = 4;

   typedef logic [4:0] flags_t;

   // Narrow word is sign, low exponent bits and the top fraction bits.
   function automatic logic [NW_DEF-1:0] pack_narrow(
      input logic               sign,
      input logic [SEW_DEF-1:0] e,
      input logic [SFW_DEF-1:0] f
   );
      return {sign, e, f};
   endfunction

endpackage

// File: rtl/fp_spec_sel.sv
// Combinational special-result select (NAN > INF > ZERO > normal) and
// IEEE flag computation.
module fp_spec_sel
   import fp_spec_pkg::*;
#(
   parameter int EW = EW_DEF,
   parameter int FW = FW_DEF
) (
   input  logic          s,
   input  logic [EW-1:0] eout,
   input  logic [FW-1:0] fout,
   input  logic [FW:0]   nan,
   input  logic          ZERO,
   input  logic          NAN,
   input  logic          INF,
   input  logic          INV,
   input  logic          OVF,
   input  logic          OVFen,
   input  logic          UNFen,
   input  logic          TINY,
   input  logic          DBZ,
   input  logic          siginx,
   output logic          sign_o,
   output logic [EW-1:0] exp_o,
   output logic [FW-1:0] frac_o,
   output flags_t        flags_o
);

   always_comb begin
      sign_o = s;
      exp_o  = eout;
      frac_o = fout;
      if (NAN) begin
         sign_o = nan[FW];
         exp_o  = '1;
         frac_o = nan[FW-1:0];
      end else if (INF) begin
         exp_o  = '1;
         frac_o = '0;
      end else if (ZERO) begin
         exp_o  = '0;
         frac_o = '0;
      end
   end

   // Overflow is meaningless once the result is already NaN or infinity.
   always_comb begin
      flags_o          = '0;
      flags_o[FLG_INV] = INV;
      flags_o[FLG_DBZ] = DBZ;
      flags_o[FLG_OVF] = OVF & ~NAN & ~INF;
      flags_o[FLG_UNF] = TINY & (UNFen | siginx);
      flags_o[FLG_INX] = siginx | (OVF & ~OVFen & ~NAN & ~INF);
   end

endmodule

// File: rtl/fp_spec_pack_pipe.sv
// Two-stage valid/ready pipeline: select + flags, then pack to wide or
// replicated narrow, with sticky status and trap signalling.
module fp_spec_pack_pipe
   import fp_spec_pkg::*;
#(
   parameter int EW  = EW_DEF,
   parameter int FW  = FW_DEF,
   parameter int SEW = SEW_DEF,
   parameter int SFW = SFW_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             s,
   input  logic [EW-1:0]    eout,
   input  logic [FW-1:0]    fout,
   input  logic [FW:0]      nan,
   input  logic             ZERO,
   input  logic             NAN,
   input  logic             INF,
   input  logic             INV,
   input  logic             OVF,
   input  logic             OVFen,
   input  logic             UNFen,
   input  logic             TINY,
   input  logic             DBZ,
   input  logic             siginx,
   input  logic             db,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [EW+FW:0]   fp_out,
   output flags_t           IEEEp,
   input  logic             flags_clr,
   input  flags_t           trap_en,
   output flags_t           sticky,
   output logic             trap,
   output flags_t           trap_cause
);

   localparam int DW = 1 + EW + FW;
   localparam int NW = 1 + SEW + SFW;

   logic          sel_sign;
   logic [EW-1:0] sel_exp;
   logic [FW-1:0] sel_frac;
   flags_t        sel_flags;

   fp_spec_sel #(.EW(EW), .FW(FW)) u_sel (
      .s(s), .eout(eout), .fout(fout), .nan(nan),
      .ZERO(ZERO), .NAN(NAN), .INF(INF), .INV(INV), .OVF(OVF),
      .OVFen(OVFen), .UNFen(UNFen), .TINY(TINY), .DBZ(DBZ), .siginx(siginx),
      .sign_o(sel_sign), .exp_o(sel_exp), .frac_o(sel_frac), .flags_o(sel_flags)
   );

   logic          v1_q, v1_d, v2_q, v2_d;
   logic          sign1_q, sign1_d, db1_q, db1_d;
   logic [EW-1:0] exp1_q, exp1_d;
   logic [FW-1:0] frac1_q, frac1_d;
   flags_t        flg1_q, flg1_d;
   logic [DW-1:0] fp_q, fp_d;
   flags_t        ieee_q, ieee_d, sticky_q, sticky_d, cause_q, cause_d;
   logic          trap_q, trap_d;

   logic          ready1, accept_in, load2, accept_out;
   logic [NW-1:0] narrow_w;
   logic [DW-1:0] packed_n;
   flags_t        hit;

   always_comb begin
      ready1    = ~v2_q | out_ready;
      in_ready  = ~v1_q | ready1;
      accept_in = in_valid & in_ready;
      load2     = v1_q & ready1;

      v1_d    = in_ready ? in_valid : v1_q;
      sign1_d = accept_in ? sel_sign  : sign1_q;
      exp1_d  = accept_in ? sel_exp   : exp1_q;
      frac1_d = accept_in ? sel_frac  : frac1_q;
      flg1_d  = accept_in ? sel_flags : flg1_q;
      db1_d   = accept_in ? db        : db1_q;

      narrow_w              = pack_narrow(sign1_q, exp1_q[SEW-1:0], frac1_q[FW-1 -: SFW]);
      packed_n              = '0;
      packed_n[2*NW-1:0]    = {narrow_w, narrow_w};

      v2_d   = ready1 ? v1_q : v2_q;
      fp_d   = load2 ? (db1_q ? {sign1_q, exp1_q, frac1_q} : packed_n) : fp_q;
      ieee_d = load2 ? flg1_q : ieee_q;
   end

   // Status bookkeeping only reacts to results actually taken downstream.
   always_comb begin
      accept_out = v2_q & out_ready;
      hit        = ieee_q & trap_en;
      sticky_d   = sticky_q;
      if (accept_out) begin
         sticky_d = flags_clr ? ieee_q : (sticky_q | ieee_q);
      end else if (flags_clr) begin
         sticky_d = '0;
      end
      trap_d  = accept_out & (|hit);
      cause_d = (accept_out && (hit != '0)) ? hit : cause_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_q     <= 1'b0;
         v2_q     <= 1'b0;
         sign1_q  <= 1'b0;
         db1_q    <= 1'b0;
         exp1_q   <= '0;
         frac1_q  <= '0;
         flg1_q   <= '0;
         fp_q     <= '0;
         ieee_q   <= '0;
         sticky_q <= '0;
         trap_q   <= 1'b0;
         cause_q  <= '0;
      end else begin
         v1_q     <= v1_d;
         v2_q     <= v2_d;
         sign1_q  <= sign1_d;
         db1_q    <= db1_d;
         exp1_q   <= exp1_d;
         frac1_q  <= frac1_d;
         flg1_q   <= flg1_d;
         fp_q     <= fp_d;
         ieee_q   <= ieee_d;
         sticky_q <= sticky_d;
         trap_q   <= trap_d;
         cause_q  <= cause_d;
      end
   end

   assign out_valid  = v2_q;
   assign fp_out     = fp_q;
   assign IEEEp      = ieee_q;
   assign sticky     = sticky_q;
   assign trap       = trap_q;
   assign trap_cause = cause_q;

endmodule
